// File: rtl/station_display_scheduler.sv
// Station display scheduler: round-robin sharing of one SSegDriver between
// NUM_STN station sensors. A winning station's temperature is latched, the
// driver is enabled until it reports a conversion, held for a fixed dwell,
// then dropped for a fixed gap before the next station is considered.
module station_display_scheduler #(
  parameter int NUM_STN     = 4,
  parameter int DWELL_CYC   = 100,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic [NUM_STN-1:0]     stn_req,
  input  logic [12*NUM_STN-1:0]  stn_temp,
  input  logic                   drv_display,
  output logic                   drv_enable,
  output logic [11:0]            drv_temp,
  output logic [NUM_STN-1:0]     grant,
  output logic [2:0]             active_id,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int MAX_AB  = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       LAST_ID      = 3'(NUM_STN - 1);

  typedef enum logic [2:0] {IDLE, LATCH, ENABLE, DWELL, GAP} state_t;

  state_t             stateReg, stateNext;
  logic [CNT_W-1:0]   cntReg, cntNext;
  logic [2:0]         rrPtrReg, rrPtrNext;
  logic [NUM_STN-1:0] grantReg, grantNext;
  logic [2:0]         activeIdReg, activeIdNext;
  logic [11:0]        drvTempReg, drvTempNext;
  logic               drvEnableReg, drvEnableNext;
  logic               busyReg, busyNext;
  logic               timeoutReg, timeoutNext;

  // Requests and temperatures padded to 8 stations so a 3-bit index is always in range.
  logic [7:0]  reqPad;
  logic [11:0] tempArr [8];

  assign reqPad = 8'(stn_req);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NUM_STN) begin : g_real
        assign tempArr[gi] = stn_temp[12*gi +: 12];
      end else begin : g_pad
        assign tempArr[gi] = 12'd0;
      end
    end
  endgenerate

  // Candidate k is the station k places above the round-robin pointer, with wrap.
  logic [2:0]         candIdx [NUM_STN];
  logic [NUM_STN-1:0] candHit;

  generate
    for (genvar gi = 0; gi < NUM_STN; gi++) begin : g_cand
      logic [3:0] sum;
      assign sum          = {1'b0, rrPtrReg} + 4'(gi);
      assign candIdx[gi]  = (sum >= 4'(NUM_STN)) ? 3'(sum - 4'(NUM_STN)) : sum[2:0];
      assign candHit[gi]  = reqPad[candIdx[gi]];
    end
  endgenerate

  logic               winHit;
  logic [2:0]         winIdx;
  logic [NUM_STN-1:0] winGrant;

  // Pick the nearest requesting candidate; scanning downward lets the lowest offset win.
  always_comb begin
    winHit = 1'b0;
    winIdx = 3'd0;
    for (int k = NUM_STN - 1; k >= 0; k--) begin
      if (candHit[k]) begin
        winHit = 1'b1;
        winIdx = candIdx[k];
      end
    end
    winGrant = NUM_STN'(1) << winIdx;
  end

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    stateNext    = stateReg;
    cntNext      = cntReg;
    rrPtrNext    = rrPtrReg;
    grantNext    = grantReg;
    activeIdNext = activeIdReg;
    drvTempNext  = drvTempReg;
    timeoutNext  = 1'b0;

    case (stateReg)
      IDLE: begin
        if (winHit) begin
          grantNext    = winGrant;
          activeIdNext = winIdx;
          cntNext      = '0;
          stateNext    = LATCH;
        end
      end
      LATCH: begin
        drvTempNext = tempArr[activeIdReg];
        cntNext     = '0;
        stateNext   = ENABLE;
      end
      ENABLE: begin
        // A display arriving on the last allowed cycle still wins over the timeout.
        if (drv_display) begin
          cntNext   = '0;
          stateNext = DWELL;
        end else if (cntReg == TIMEOUT_LAST) begin
          timeoutNext = 1'b1;
          cntNext     = '0;
          stateNext   = GAP;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      DWELL: begin
        if (cntReg == DWELL_LAST) begin
          cntNext   = '0;
          stateNext = GAP;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      GAP: begin
        if (cntReg == GAP_LAST) begin
          cntNext      = '0;
          grantNext    = '0;
          activeIdNext = 3'd0;
          rrPtrNext    = (activeIdReg == LAST_ID) ? 3'd0 : activeIdReg + 3'd1;
          stateNext    = IDLE;
        end else begin
          cntNext = cntReg + 1'b1;
        end
      end
      default: begin
        cntNext   = '0;
        stateNext = IDLE;
      end
    endcase

    drvEnableNext = (stateNext == ENABLE) || (stateNext == DWELL);
    busyNext      = (stateNext != IDLE);
  end

  // State and output registers; reset clears everything immediately, even mid-service.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      stateReg     <= IDLE;
      cntReg       <= '0;
      rrPtrReg     <= 3'd0;
      grantReg     <= '0;
      activeIdReg  <= 3'd0;
      drvTempReg   <= 12'd0;
      drvEnableReg <= 1'b0;
      busyReg      <= 1'b0;
      timeoutReg   <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      rrPtrReg     <= rrPtrNext;
      grantReg     <= grantNext;
      activeIdReg  <= activeIdNext;
      drvTempReg   <= drvTempNext;
      drvEnableReg <= drvEnableNext;
      busyReg      <= busyNext;
      timeoutReg   <= timeoutNext;
    end
  end

  assign drv_enable  = drvEnableReg;
  assign drv_temp    = drvTempReg;
  assign grant       = grantReg;
  assign active_id   = activeIdReg;
  assign busy        = busyReg;
  assign timeout_err = timeoutReg;

endmodule

// File: tb/tb_station_display_scheduler.sv
// Bench for station_display_scheduler: a table of service transactions with
// hand-computed grants/temperatures, plus hand-written glitch and reset sequences.
module tb_station_display_scheduler;

  localparam int NUM_STN     = 4;
  localparam int DWELL_CYC   = 100;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 200;

  localparam logic [47:0] TEMPS = {12'd2395, 12'd1718, 12'd1379, 12'd362};

  logic                  CLK = 1'b0;
  logic                  RESETn = 1'b0;
  logic [NUM_STN-1:0]    stn_req = '0;
  logic [12*NUM_STN-1:0] stn_temp = '0;
  logic                  drv_display = 1'b0;
  logic                  drv_enable;
  logic [11:0]           drv_temp;
  logic [NUM_STN-1:0]    grant;
  logic [2:0]            active_id;
  logic                  busy;
  logic                  timeout_err;

  station_display_scheduler #(
    .NUM_STN(NUM_STN), .DWELL_CYC(DWELL_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .stn_req(stn_req), .stn_temp(stn_temp),
    .drv_display(drv_display), .drv_enable(drv_enable), .drv_temp(drv_temp),
    .grant(grant), .active_id(active_id), .busy(busy), .timeout_err(timeout_err)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // dispDelay: cycles after enable rise before drv_display is raised; -1 = never.
  typedef struct {
    logic [3:0]  req;
    int          dispDelay;
    logic [3:0]  expGrant;
    logic [2:0]  expId;
    logic [11:0] expTemp;
  } vec_t;

  vec_t vecs [12];

  // One full service: arbitration, latency, latched temp, dwell/timeout length, gap length.
  task automatic runService(input vec_t v, input int tag, input bit toggleReq);
    int  n;
    int  hi;
    int  gapCnt;
    int  toHigh;
    bit  enHigh;
    stn_req  = v.req;
    stn_temp = TEMPS;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (grant == '0 && n < 20);
    chk("req_to_grant_cycles", n, 1);
    chk("grant", 32'(grant), 32'(v.expGrant));
    chk("active_id", 32'(active_id), 32'(v.expId));
    chk("busy_in_service", 32'(busy), 1);
    chk("enable_before_rise", 32'(drv_enable), 0);
    @(negedge CLK);
    chk("enable_rise", 32'(drv_enable), 1);
    chk("drv_temp", 32'(drv_temp), 32'(v.expTemp));
    stn_temp = ~TEMPS;
    hi = 1;
    if (v.dispDelay >= 0) begin
      repeat (v.dispDelay) @(negedge CLK);
      chk("enable_waiting", 32'(drv_enable), 1);
      drv_display = 1'b1;
      if (toggleReq) begin
        fork
          begin
            repeat (100) #5 stn_req[0] = ~stn_req[0];
            stn_req = '0;
          end
        join_none
      end
      hi = 0;
      @(negedge CLK);
      while (drv_enable && hi < 400) begin
        hi++;
        if (hi == 10) drv_display = 1'b0;
        @(negedge CLK);
      end
      drv_display = 1'b0;
      chk("dwell_cycles", hi, DWELL_CYC);
    end else begin
      @(negedge CLK);
      while (drv_enable && hi < 400) begin
        hi++;
        @(negedge CLK);
      end
      chk("timeout_enable_cycles", hi, TIMEOUT_CYC);
    end
    chk("drv_temp_hold", 32'(drv_temp), 32'(v.expTemp));
    chk("gap_grant_held", 32'(grant), 32'(v.expGrant));
    gapCnt = 0;
    toHigh = 0;
    enHigh = 1'b0;
    while (grant != '0 && gapCnt < 20) begin
      if (drv_enable) enHigh = 1'b1;
      if (timeout_err) toHigh++;
      gapCnt++;
      @(negedge CLK);
    end
    chk("gap_cycles", gapCnt, GAP_CYC);
    chk("gap_enable_low", 32'(enHigh), 0);
    chk("timeout_pulse_cycles", toHigh, (v.dispDelay < 0) ? 1 : 0);
    chk("idle_busy", 32'(busy), 0);
    $display("svc %0d req=%b grant=%b id=%0d temp=%0d enable_cycles=%0d gap=%0d",
             tag, v.req, v.expGrant, v.expId, v.expTemp, hi, gapCnt);
  endtask

  vec_t g;
  int   extra;

  initial begin
    //               req      delay  grant    id    temp
    vecs[0]  = '{4'b1111,   3, 4'b0001, 3'd0, 12'd362};
    vecs[1]  = '{4'b1111,   3, 4'b0010, 3'd1, 12'd1379};
    vecs[2]  = '{4'b1111,   3, 4'b0100, 3'd2, 12'd1718};
    vecs[3]  = '{4'b1111,   3, 4'b1000, 3'd3, 12'd2395};
    vecs[4]  = '{4'b0001,   5, 4'b0001, 3'd0, 12'd362};
    vecs[5]  = '{4'b0001,   5, 4'b0001, 3'd0, 12'd362};
    vecs[6]  = '{4'b0101,   2, 4'b0100, 3'd2, 12'd1718};
    vecs[7]  = '{4'b0101,   2, 4'b0001, 3'd0, 12'd362};
    vecs[8]  = '{4'b0101,   2, 4'b0100, 3'd2, 12'd1718};
    vecs[9]  = '{4'b1010,  -1, 4'b1000, 3'd3, 12'd2395};
    vecs[10] = '{4'b1010,   0, 4'b0010, 3'd1, 12'd1379};
    vecs[11] = '{4'b0100, TIMEOUT_CYC - 1, 4'b0100, 3'd2, 12'd1718};

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_drv_enable", 32'(drv_enable), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_active_id", 32'(active_id), 0);
    chk("rst_drv_temp", 32'(drv_temp), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    RESETn = 1'b1;

    foreach (vecs[i]) runService(vecs[i], i, 1'b0);

    // Request glitches during dwell: no enable glitch, no extra service afterwards
    g = '{4'b0001, 4, 4'b0001, 3'd0, 12'd362};
    runService(g, 100, 1'b1);
    extra = 0;
    repeat (10) begin
      @(negedge CLK);
      if (grant != '0 || busy || drv_enable) extra++;
    end
    chk("no_extra_service", extra, 0);

    // Reset mid-dwell of station 2 (pointer at 1), then arbitration restarts at 0
    stn_req  = 4'b0101;
    stn_temp = TEMPS;
    @(negedge CLK);
    chk("pre_reset_grant", 32'(grant), 32'(4'b0100));
    @(negedge CLK);
    drv_display = 1'b1;
    repeat (20) @(negedge CLK);
    chk("pre_reset_enable", 32'(drv_enable), 1);
    #2;
    RESETn = 1'b0;
    drv_display = 1'b0;
    #1;
    chk("async_rst_enable", 32'(drv_enable), 0);
    chk("async_rst_grant", 32'(grant), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_drv_temp", 32'(drv_temp), 0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    chk("post_reset_grant", 32'(grant), 32'(4'b0001));
    chk("post_reset_active_id", 32'(active_id), 0);
    $display("reset mid-dwell: grant after release=%b", grant);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
